pe_dbuf: RTL and testbench
==========================

Name: pe_dbuf

Overview:
Parametrised weight-stationary systolic processing element, the successor to the current fixed-width PE. Adds signed arithmetic with a separate accumulator width, optional saturation and a double-buffered weight. The next weight tile shifts in through a vertical weight chain and is captured into a shadow register while the active weight keeps computing. A hold-style stall and valid tagging replace zero-forcing on idle cycles. Instantiated in a ROWS x COLS grid inside the systolic array; the array controller drives go, w_latch and w_swap to all PEs.

Parameters:
IN_W, 8, width of activation and weight (signed two's complement)
ACC_W, 24, width of partial sum in/out (signed); must satisfy ACC_W >= 2*IN_W
SAT, 1, 1 = saturate partial sum to ACC_W signed range; 0 = wrap modulo 2^ACC_W

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
go  input  1  compute enable; 0 = stall, compute-path registers hold
in_left  input  IN_W  activation from left neighbour
in_left_vld  input  1  activation valid
in_up  input  ACC_W  partial sum from upper neighbour
w_in  input  IN_W  weight chain input from upper neighbour
w_in_vld  input  1  weight chain valid
w_latch  input  1  capture w_in into shadow weight
w_swap  input  1  promote shadow weight to active weight
w_zero  input  1  force active weight to 0
out_right  output  IN_W  registered activation to right neighbour
out_right_vld  output  1  registered activation valid
out_down  output  ACC_W  registered partial sum to lower neighbour
out_down_vld  output  1  partial-sum valid
w_out  output  IN_W  registered weight chain to lower neighbour
w_out_vld  output  1  weight chain valid out
w_ready  output  1  shadow weight holds an unswapped value
sat_flag  output  1  sticky: saturation occurred
swap_err  output  1  sticky: w_swap asserted while w_ready=0

Behaviour:
- Reset (rst=1 at rising edge): all outputs, active weight, shadow weight and state are 0; weight FSM = EMPTY. Reset overrides every other input in the same cycle.
- Weight chain, independent of go: w_out <= w_in and w_out_vld <= w_in_vld every cycle. Latency 1.
- Weight FSM, states EMPTY (w_ready=0) and FULL (w_ready=1); independent of go:
  - w_latch: shadow <= w_in. Next state FULL.
  - w_swap in FULL: active <= shadow. Next state EMPTY, unless w_latch is asserted in the same cycle.
  - w_swap and w_latch together in FULL: active <= old shadow, shadow <= w_in, state stays FULL.
  - w_swap in EMPTY: active unchanged, swap_err <= 1. If w_latch is also asserted it captures normally.
  - w_zero: active <= 0. Takes priority over w_swap. Shadow and FSM still update as if the swap occurred.
- Compute path, active weight value at the start of the cycle:
  - go=1: out_right <= in_left; out_right_vld <= in_left_vld.
  - go=1, in_left_vld=1: prod = signed(in_left) * signed(active), 2*IN_W bits, sign-extended to ACC_W. sum = in_up + prod, computed at ACC_W+1 bits. out_down <= sum, clipped or wrapped per SAT. out_down_vld <= 1.
  - go=1, in_left_vld=0: out_down <= in_up (pass-through), out_down_vld <= 0.
  - go=0: out_right, out_right_vld, out_down and out_down_vld hold their values. Latency 1 cycle when go=1.
- Saturation (SAT=1): sum > 2^(ACC_W-1)-1 gives max; sum < -2^(ACC_W-1) gives min. sat_flag <= 1 when clipping occurs. sat_flag and swap_err clear only on rst.
- A swap takes effect for the compute cycle after the swap edge. Results are computed with exactly one weight, never a blend.

Test Plan:
- Reset mid-operation: run MACs, assert rst for 1 cycle -> next cycle all outputs 0, w_ready=0, flags 0.
- Basic MAC (IN_W=8, ACC_W=24): latch+swap w=-3, then in_left=7 vld=1, in_up=100, go=1 -> out_down=79 with vld=1 next cycle; out_right=7.
- Double buffer: active=2, w_latch w_in=5 while streaming in_left=4, in_up=0 -> out_down=8. Then w_swap -> following result 20; w_ready falls after the swap.
- Simultaneous swap+latch in FULL (shadow=5, w_in=9) -> active=5, shadow=9, w_ready stays 1. Then w_swap in EMPTY -> active unchanged, swap_err=1.
- Saturation (ACC_W=16, SAT=1): in_up=32760, in_left=10, w=5 -> out_down=32767, sat_flag=1. With SAT=0 -> out_down=-32726.
- Stall: go=0 for 3 cycles with changing inputs -> compute outputs frozen, while w_out still follows w_in each cycle.

Source files
------------

// File: rtl/pe_dbuf.sv
// Weight-stationary systolic PE with a double-buffered weight: the next weight is
// latched into a shadow register from the weight chain while the active weight computes.
module pe_dbuf #(
   parameter int IN_W  = 8,
   parameter int ACC_W = 24,
   parameter bit SAT   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [IN_W-1:0]  in_left,
   input  logic             in_left_vld,
   input  logic [ACC_W-1:0] in_up,
   input  logic [IN_W-1:0]  w_in,
   input  logic             w_in_vld,
   input  logic             w_latch,
   input  logic             w_swap,
   input  logic             w_zero,
   output logic [IN_W-1:0]  out_right,
   output logic             out_right_vld,
   output logic [ACC_W-1:0] out_down,
   output logic             out_down_vld,
   output logic [IN_W-1:0]  w_out,
   output logic             w_out_vld,
   output logic             w_ready,
   output logic             sat_flag,
   output logic             swap_err
);

   // Valid semantics: there is no back-pressure. A *_vld bit qualifies its data on
   // the same cycle; go=0 freezes the compute outputs, the weight chain never stalls.

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} wstate_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   wstate_t           state, state_nxt;
   logic [IN_W-1:0]   active, active_nxt;
   logic [IN_W-1:0]   shadow, shadow_nxt;
   logic              swap_err_nxt;

   logic [2*IN_W-1:0] a_ext, w_ext, prod;
   logic [ACC_W:0]    prod_ext, sum;
   logic [ACC_W-1:0]  down_nxt;
   logic              clip;

   assign w_ready = (state == FULL);

   // Weight double-buffer FSM; w_zero only overrides the active register.
   always_comb begin
      state_nxt    = state;
      active_nxt   = active;
      shadow_nxt   = shadow;
      swap_err_nxt = swap_err;
      if (w_latch) begin
         shadow_nxt = w_in;
         state_nxt  = FULL;
      end
      if (w_swap) begin
         if (state == FULL) begin
            active_nxt = shadow;
            if (!w_latch) state_nxt = EMPTY;
         end else begin
            swap_err_nxt = 1'b1;
         end
      end
      if (w_zero) active_nxt = '0;
   end

   // Low 2*IN_W bits of the product of sign-extended operands are the exact signed product.
   assign a_ext    = {{IN_W{in_left[IN_W-1]}}, in_left};
   assign w_ext    = {{IN_W{active[IN_W-1]}}, active};
   assign prod     = a_ext * w_ext;
   assign prod_ext = {{(ACC_W+1-2*IN_W){prod[2*IN_W-1]}}, prod};
   assign sum      = {in_up[ACC_W-1], in_up} + prod_ext;

   always_comb begin
      down_nxt = in_up;
      clip     = 1'b0;
      if (in_left_vld) begin
         if (SAT && (sum[ACC_W] != sum[ACC_W-1])) begin
            down_nxt = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            clip     = 1'b1;
         end else begin
            down_nxt = sum[ACC_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= EMPTY;
         active        <= '0;
         shadow        <= '0;
         out_right     <= '0;
         out_right_vld <= 1'b0;
         out_down      <= '0;
         out_down_vld  <= 1'b0;
         w_out         <= '0;
         w_out_vld     <= 1'b0;
         sat_flag      <= 1'b0;
         swap_err      <= 1'b0;
      end else begin
         state     <= state_nxt;
         active    <= active_nxt;
         shadow    <= shadow_nxt;
         swap_err  <= swap_err_nxt;
         w_out     <= w_in;
         w_out_vld <= w_in_vld;
         if (go) begin
            out_right     <= in_left;
            out_right_vld <= in_left_vld;
            out_down      <= down_nxt;
            out_down_vld  <= in_left_vld;
            if (clip) sat_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pe_dbuf.sv
// Bench for pe_dbuf: a 24-bit saturating PE plus 16-bit saturating and wrapping PEs
// sharing the same stimulus, checked against an integer reference model.
module tb_pe_dbuf;
   localparam int IN_W  = 8;
   localparam int ACC_W = 24;
   localparam int A16   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, go, in_left_vld, w_in_vld, w_latch, w_swap, w_zero;
   logic [IN_W-1:0]  in_left, w_in;
   logic [ACC_W-1:0] in_up;
   logic [A16-1:0]   in_up16;
   assign in_up16 = in_up[A16-1:0];

   logic [IN_W-1:0]  out_right, w_out;
   logic [ACC_W-1:0] out_down;
   logic out_right_vld, out_down_vld, w_out_vld, w_ready, sat_flag, swap_err;

   logic [IN_W-1:0]  s_out_right, s_w_out;
   logic [A16-1:0]   s_out_down;
   logic s_out_right_vld, s_out_down_vld, s_w_out_vld, s_w_ready, s_sat_flag, s_swap_err;

   logic [IN_W-1:0]  r_out_right, r_w_out;
   logic [A16-1:0]   r_out_down;
   logic r_out_right_vld, r_out_down_vld, r_w_out_vld, r_w_ready, r_sat_flag, r_swap_err;

   pe_dbuf #(.IN_W(IN_W), .ACC_W(ACC_W), .SAT(1'b1)) u_dut (
      .clk(clk), .rst(rst), .go(go), .in_left(in_left), .in_left_vld(in_left_vld),
      .in_up(in_up), .w_in(w_in), .w_in_vld(w_in_vld), .w_latch(w_latch),
      .w_swap(w_swap), .w_zero(w_zero), .out_right(out_right),
      .out_right_vld(out_right_vld), .out_down(out_down), .out_down_vld(out_down_vld),
      .w_out(w_out), .w_out_vld(w_out_vld), .w_ready(w_ready), .sat_flag(sat_flag),
      .swap_err(swap_err));

   pe_dbuf #(.IN_W(IN_W), .ACC_W(A16), .SAT(1'b1)) u_s16 (
      .clk(clk), .rst(rst), .go(go), .in_left(in_left), .in_left_vld(in_left_vld),
      .in_up(in_up16), .w_in(w_in), .w_in_vld(w_in_vld), .w_latch(w_latch),
      .w_swap(w_swap), .w_zero(w_zero), .out_right(s_out_right),
      .out_right_vld(s_out_right_vld), .out_down(s_out_down), .out_down_vld(s_out_down_vld),
      .w_out(s_w_out), .w_out_vld(s_w_out_vld), .w_ready(s_w_ready), .sat_flag(s_sat_flag),
      .swap_err(s_swap_err));

   pe_dbuf #(.IN_W(IN_W), .ACC_W(A16), .SAT(1'b0)) u_w16 (
      .clk(clk), .rst(rst), .go(go), .in_left(in_left), .in_left_vld(in_left_vld),
      .in_up(in_up16), .w_in(w_in), .w_in_vld(w_in_vld), .w_latch(w_latch),
      .w_swap(w_swap), .w_zero(w_zero), .out_right(r_out_right),
      .out_right_vld(r_out_right_vld), .out_down(r_out_down), .out_down_vld(r_out_down_vld),
      .w_out(r_w_out), .w_out_vld(r_w_out_vld), .w_ready(r_w_ready), .sat_flag(r_sat_flag),
      .swap_err(r_swap_err));

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state, kept as plain signed integers.
   longint m_active, m_shadow, m_right, m_down24, m_down16s, m_down16w, m_w_out;
   bit     m_full, m_swap_err, m_sat24, m_sat16, m_right_vld, m_down_vld, m_w_out_vld;

   function automatic longint ref_mac(input longint up, input longint a, input longint w,
                                      input int accw, input bit sat, output bit clipped);
      longint s, mx, mn, span;
      s       = up + a * w;
      span    = longint'(1) <<< accw;
      mx      = (longint'(1) <<< (accw - 1)) - 1;
      mn      = -mx - 1;
      clipped = 1'b0;
      if (sat) begin
         if (s > mx) begin s = mx; clipped = 1'b1; end
         else if (s < mn) begin s = mn; clipped = 1'b1; end
      end else begin
         s = s % span;
         if (s > mx) s = s - span;
         if (s < mn) s = s + span;
      end
      return s;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input longint exp, input int w);
      logic [63:0] e;
      e = 64'(exp) & ((64'd1 << w) - 64'd1);
      n_checks++;
      assert (obs === e) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".out_right"},     64'(out_right),     m_right,     IN_W);
      chk({tag, ".out_right_vld"}, 64'(out_right_vld), m_right_vld, 1);
      chk({tag, ".out_down"},      64'(out_down),      m_down24,    ACC_W);
      chk({tag, ".out_down_vld"},  64'(out_down_vld),  m_down_vld,  1);
      chk({tag, ".w_out"},         64'(w_out),         m_w_out,     IN_W);
      chk({tag, ".w_out_vld"},     64'(w_out_vld),     m_w_out_vld, 1);
      chk({tag, ".w_ready"},       64'(w_ready),       m_full,      1);
      chk({tag, ".sat_flag"},      64'(sat_flag),      m_sat24,     1);
      chk({tag, ".swap_err"},      64'(swap_err),      m_swap_err,  1);
      chk({tag, ".s16.out_down"},  64'(s_out_down),    m_down16s,   A16);
      chk({tag, ".s16.sat_flag"},  64'(s_sat_flag),    m_sat16,     1);
      chk({tag, ".w16.out_down"},  64'(r_out_down),    m_down16w,   A16);
      chk({tag, ".w16.sat_flag"},  64'(r_sat_flag),    0,           1);
   endtask

   // Advance one clock: predict from the inputs applied before the edge, then compare.
   task automatic step(input string tag);
      longint a, up24, up16;
      bit     c24, c16, cw;
      if (rst) begin
         m_active = 0; m_shadow = 0; m_full = 0; m_swap_err = 0; m_sat24 = 0; m_sat16 = 0;
         m_right = 0; m_right_vld = 0; m_down24 = 0; m_down16s = 0; m_down16w = 0;
         m_down_vld = 0; m_w_out = 0; m_w_out_vld = 0;
      end else begin
         m_w_out     = longint'(w_in);
         m_w_out_vld = w_in_vld;
         if (go) begin
            a           = longint'($signed(in_left));
            up24        = longint'($signed(in_up));
            up16        = longint'($signed(in_up[A16-1:0]));
            m_right     = longint'(in_left);
            m_right_vld = in_left_vld;
            m_down_vld  = in_left_vld;
            if (in_left_vld) begin
               m_down24  = ref_mac(up24, a, m_active, ACC_W, 1'b1, c24);
               m_down16s = ref_mac(up16, a, m_active, A16, 1'b1, c16);
               m_down16w = ref_mac(up16, a, m_active, A16, 1'b0, cw);
               if (c24) m_sat24 = 1;
               if (c16) m_sat16 = 1;
            end else begin
               m_down24  = up24;
               m_down16s = up16;
               m_down16w = up16;
            end
         end
         begin
            longint na, ns;
            bit     nf;
            na = m_active; ns = m_shadow; nf = m_full;
            if (w_latch) begin ns = longint'($signed(w_in)); nf = 1; end
            if (w_swap) begin
               if (m_full) begin na = m_shadow; if (!w_latch) nf = 0; end
               else m_swap_err = 1;
            end
            if (w_zero) na = 0;
            m_active = na; m_shadow = ns; m_full = nf;
         end
      end
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   task automatic idle();
      rst = 0; go = 0; in_left_vld = 0; w_in_vld = 0;
      w_latch = 0; w_swap = 0; w_zero = 0;
   endtask

   initial begin
      rst = 1; go = 0; in_left = '0; in_left_vld = 0; in_up = '0; w_in = '0;
      w_in_vld = 0; w_latch = 0; w_swap = 0; w_zero = 0;
      step("reset");
      idle();

      // Basic MAC with w=-3
      w_in = 8'hFD; w_latch = 1; step("b_latch");
      w_latch = 0; w_swap = 1; step("b_swap");
      w_swap = 0; go = 1; in_left = 8'd7; in_left_vld = 1; in_up = 24'd100;
      step("basic");
      chk("basic.lit_down", 64'(out_down), 79, ACC_W);
      chk("basic.lit_right", 64'(out_right), 7, IN_W);

      // Double buffer: active=2, shadow 5 loaded while computing
      idle(); w_in = 8'd2; w_latch = 1; step("db_l2");
      w_latch = 0; w_swap = 1; step("db_s2");
      w_swap = 0; go = 1; in_left = 8'd4; in_left_vld = 1; in_up = '0;
      w_in = 8'd5; w_latch = 1; step("db_latch");
      chk("db_latch.lit_down", 64'(out_down), 8, ACC_W);
      w_latch = 0; w_swap = 1; step("db_swap");
      chk("db_swap.lit_down", 64'(out_down), 8, ACC_W);
      chk("db_swap.lit_ready", 64'(w_ready), 0, 1);
      w_swap = 0; step("db_new");
      chk("db_new.lit_down", 64'(out_down), 20, ACC_W);

      // Simultaneous swap+latch in FULL, then swap in EMPTY
      in_left = 8'd1; w_in = 8'd6; w_latch = 1; step("sim_l6");
      w_in = 8'd9; w_latch = 1; w_swap = 1; step("sim_both");
      w_latch = 0; w_swap = 0; step("sim_use");
      chk("sim_use.lit_down", 64'(out_down), 6, ACC_W);
      chk("sim_use.lit_ready", 64'(w_ready), 1, 1);
      w_swap = 1; step("sim_s9");
      w_swap = 1; step("swap_empty");
      chk("swap_empty.lit_err", 64'(swap_err), 1, 1);
      w_swap = 0; step("after_err");
      chk("after_err.lit_down", 64'(out_down), 9, ACC_W);

      // Saturation at 16 bits, and at 24 bits
      idle(); w_in = 8'd5; w_latch = 1; step("sat_l5");
      w_latch = 0; w_swap = 1; step("sat_s5");
      w_swap = 0; go = 1; in_left = 8'd10; in_left_vld = 1; in_up = 24'd32760;
      step("sat16");
      chk("sat16.lit_sat", 64'(s_out_down), 32767, A16);
      chk("sat16.lit_flag", 64'(s_sat_flag), 1, 1);
      chk("sat16.lit_wrap", 64'(r_out_down), -32726, A16);
      in_left = 8'd127; in_up = 24'd8388600; step("sat24");
      chk("sat24.lit_sat", 64'(out_down), 8388607, ACC_W);
      chk("sat24.lit_flag", 64'(sat_flag), 1, 1);

      // Stall with changing inputs; weight chain keeps moving
      go = 0;
      for (int i = 0; i < 3; i++) begin
         in_left = IN_W'($urandom); in_left_vld = 1'($urandom); in_up = ACC_W'($urandom);
         w_in = IN_W'($urandom); w_in_vld = 1'($urandom);
         step("stall");
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst         = ($urandom_range(0, 59) == 0);
         go          = ($urandom_range(0, 3) != 0);
         in_left     = IN_W'($urandom);
         in_left_vld = ($urandom_range(0, 3) != 0);
         in_up       = ($urandom_range(0, 3) == 0) ? ACC_W'($urandom_range(32700, 32767))
                                                   : ACC_W'($urandom);
         w_in        = IN_W'($urandom);
         w_in_vld    = 1'($urandom);
         w_latch     = ($urandom_range(0, 3) == 0);
         w_swap      = ($urandom_range(0, 3) == 0);
         w_zero      = ($urandom_range(0, 15) == 0);
         step("rand");
      end

      // Reset in the middle of activity
      idle(); go = 1; in_left_vld = 1; w_latch = 1; w_in_vld = 1; rst = 1;
      step("reset_mid");
      chk("reset_mid.lit_down", 64'(out_down), 0, ACC_W);
      chk("reset_mid.lit_ready", 64'(w_ready), 0, 1);
      chk("reset_mid.lit_flags", 64'({sat_flag, swap_err}), 0, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
